// File: rtl/div_seq.sv
// Sequential signed 32-bit divider: restoring algorithm on magnitudes,
// one quotient bit per cycle, sign fix-up in a final cycle (33-cycle latency).
module div_seq (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div0
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  logic [1:0]  state_r;
  logic [4:0]  cnt_r;
  logic [31:0] rem_r;
  logic [31:0] quo_r;
  logic [31:0] dvs_r;
  logic        sign_q_r;
  logic        sign_rem_r;

  logic [32:0] shift_s;
  logic [32:0] trial_s;

  // Magnitude as 32-bit unsigned; 0x80000000 maps to itself.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

  function automatic logic [31:0] neg_if(input logic sel, input logic [31:0] v);
    return sel ? (32'd0 - v) : v;
  endfunction

  // One restoring step: shifted partial remainder minus divisor, 33 bits wide.
  always_comb begin
    shift_s = {rem_r, quo_r[31]};
    trial_s = shift_s - {1'b0, dvs_r};
  end

  // Control FSM, datapath registers and registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      cnt_r      <= 5'd0;
      rem_r      <= 32'd0;
      quo_r      <= 32'd0;
      dvs_r      <= 32'd0;
      sign_q_r   <= 1'b0;
      sign_rem_r <= 1'b0;
      hi         <= 32'd0;
      lo         <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      div0       <= 1'b0;
    end else begin
      done <= 1'b0;
      div0 <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start && (b == 32'd0)) begin
            div0 <= 1'b1;
          end else if (start) begin
            rem_r      <= 32'd0;
            quo_r      <= abs32(a);
            dvs_r      <= abs32(b);
            sign_q_r   <= a[31] ^ b[31];
            sign_rem_r <= a[31];
            cnt_r      <= 5'd0;
            busy       <= 1'b1;
            state_r    <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (!trial_s[32]) begin
            rem_r <= trial_s[31:0];
            quo_r <= {quo_r[30:0], 1'b1};
          end else begin
            rem_r <= shift_s[31:0];
            quo_r <= {quo_r[30:0], 1'b0};
          end
          cnt_r <= cnt_r + 5'd1;
          if (cnt_r == 5'd31) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          lo      <= neg_if(sign_q_r, quo_r);
          hi      <= neg_if(sign_rem_r, rem_r);
          done    <= 1'b1;
          busy    <= 1'b0;
          cnt_r   <= 5'd0;
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
          cnt_r   <= 5'd0;
        end
      endcase
    end
  end

endmodule
